mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the LC-3 datapath's MAR/MDR memory accesses.
- Accepts CPU read/write requests (CE_n/OE_n/WE_n strobes plus address and write data) and serves them from an internal word array or from memory-mapped I/O.
- Returns read data on Data_to_CPU and signals completion with a one-cycle R (memory-ready) pulse after a configurable number of wait states.
- The control FSM waits on R in its memory states; the datapath loads MDR from Data_to_CPU when R is seen.

Parameters:
- DEPTH_LOG2, 8, log2 of internal array depth in 16-bit words (array covers addresses 0 .. 2^DEPTH_LOG2-1).
- WAIT_CYCLES, 2, wait states between request acceptance and R; legal range 0..15.
- IO_ADDR, 16'hFFFF, address of memory-mapped I/O word (read = Switches, write = HEX_out).

Ports:
- Clk  input  1  system clock; all state changes on rising edge.
- Reset  input  1  asynchronous, active-low reset (0 = reset).
- CE_n  input  1  chip enable, active-low.
- OE_n  input  1  read strobe, active-low.
- WE_n  input  1  write strobe, active-low.
- ADDR  input  16  word address (from MAR).
- Data_from_CPU  input  16  write data (from MDR).
- Switches  input  16  board switch value, returned on reads of IO_ADDR.
- Data_to_CPU  output  16  registered read data.
- R  output  1  memory ready; one-cycle pulse on completion of every accepted request.
- Busy  output  1  high whenever the FSM is not in IDLE.
- HEX_out  output  16  I/O register written by writes to IO_ADDR.

Behaviour:
- Reset (Reset=0, asynchronous): FSM=IDLE, counter=0, R=0, Data_to_CPU=16'h0000, HEX_out=16'h0000, captured request registers cleared. Array contents are not reset.
- Reset asserted mid-transaction aborts it: no write is performed and no R is issued.
- Request active = CE_n==0 and (OE_n==0 or WE_n==0). If both strobes are low, the request is a write; the read is ignored.
- States:
  - IDLE: on an active request, capture ADDR, Data_from_CPU and op (read/write), load counter=WAIT_CYCLES, go to WAIT.
  - WAIT: if counter==0, go to DONE; otherwise decrement the counter and stay.
  - DONE: R=1 for exactly this cycle, and the operation executes at the end of this cycle. If the request is still active, go to HOLD; otherwise go to IDLE.
  - HOLD: stay until the request is inactive, then go to IDLE. This prevents a held strobe from being serviced twice.
- Latency: acceptance edge at cycle 0; R high during cycle WAIT_CYCLES+2 counted from the accept cycle. Equivalently, R appears WAIT_CYCLES+1 full cycles after the first cycle of WAIT; with WAIT_CYCLES=0, WAIT lasts one cycle.
- Captured values are used throughout. Changes to ADDR/data/strobes after acceptance have no effect, and withdrawing the request during WAIT does not cancel it: R still pulses, then the FSM returns to IDLE.
- Address decode, applied to the captured address:
  - ADDR==IO_ADDR: I/O.
  - ADDR[15:DEPTH_LOG2]==0: array, indexed by ADDR[DEPTH_LOG2-1:0].
  - Anything else: unmapped.
- Read:
  - Data_to_CPU is loaded on the DONE edge with the array word, or with Switches sampled in the DONE cycle.
  - Unmapped reads return 16'h0000.
  - Data_to_CPU holds its value until the next read completes; writes do not change it.
- Write:
  - Array word or HEX_out is updated on the DONE edge.
  - Unmapped writes are dropped silently but still complete with R.
- A new request is never accepted in WAIT, DONE or HOLD. The earliest back-to-back acceptance is the cycle after DONE, when DONE goes to IDLE.
- Busy = (state != IDLE). R is only ever high in DONE.

Test Plan:
- Reset=0 for 2 cycles with strobes active -> R=0, Busy=0, Data_to_CPU=0, HEX_out=0. After release, the first request is accepted on the next edge.
- WAIT_CYCLES=2: write 16'hBEEF to 16'h0010 with strobes held -> R pulses once, 4 cycles after acceptance; FSM sits in HOLD until CE_n=1. Then read 16'h0010 -> Data_to_CPU=16'hBEEF on the R cycle.
- Read of 16'hFFFF with Switches=16'h1234, Switches changed to 16'h5678 during WAIT -> Data_to_CPU=16'h5678. Write 16'h00A5 to 16'hFFFF -> HEX_out=16'h00A5 after R.
- Read 16'h0100 (unmapped, DEPTH_LOG2=8) -> Data_to_CPU=16'h0000 with R. Write 16'h7777 to 16'h0100, then read 16'h0000 -> array word 0 unchanged.
- CE_n, OE_n and WE_n all low with ADDR=16'h0020, data 16'h0042 -> treated as a write (read 16'h0020 afterwards returns 16'h0042). Request withdrawn one cycle after acceptance -> R still pulses once, FSM goes DONE->IDLE.
- Reset pulsed low during WAIT of a write of 16'hCAFE to 16'h0005 (word previously 16'h1111) -> no R; read of 16'h0005 after reset returns 16'h1111.

Source files
------------

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - MAR/MDR memory responder with wait states, word array and memory-mapped I/O
module mem_responder #(
    parameter int          DEPTH_LOG2  = 8,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        CE_n,
    input  logic        OE_n,
    input  logic        WE_n,
    input  logic [15:0] ADDR,
    input  logic [15:0] Data_from_CPU,
    input  logic [15:0] Switches,
    output logic [15:0] Data_to_CPU,
    output logic        R,
    output logic        Busy,
    output logic [15:0] HEX_out
);

    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_is_write;
    logic [15:0] r_dout;
    logic [15:0] r_hex;
    logic [15:0] r_mem [DEPTH];

    logic                  w_req;
    logic                  w_done;
    logic                  w_is_io;
    logic                  w_is_arr;
    logic [DEPTH_LOG2-1:0] w_idx;

    assign w_req    = !CE_n && (!OE_n || !WE_n);
    assign w_done   = (r_state == S_DONE);
    assign w_is_io  = (r_addr == IO_ADDR);
    assign w_is_arr = !w_is_io && ((r_addr >> DEPTH_LOG2) == 16'd0);
    assign w_idx    = r_addr[DEPTH_LOG2-1:0];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_addr     <= 16'h0000;
            r_wdata    <= 16'h0000;
            r_is_write <= 1'b0;
            r_dout     <= 16'h0000;
            r_hex      <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_addr     <= ADDR;
                        r_wdata    <= Data_from_CPU;
                        r_is_write <= !WE_n;
                        r_cnt      <= WAIT_INIT;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    // Operation commits here; unmapped writes fall through untouched
                    if (r_is_write) begin
                        if (w_is_io) begin
                            r_hex <= r_wdata;
                        end
                    end else if (w_is_io) begin
                        r_dout <= Switches;
                    end else if (w_is_arr) begin
                        r_dout <= r_mem[w_idx];
                    end else begin
                        r_dout <= 16'h0000;
                    end
                    r_state <= w_req ? S_HOLD : S_IDLE;
                end
                default: begin
                    if (!w_req) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Array is not reset; the Reset gate keeps a reset landing on the DONE edge from writing
    always_ff @(posedge Clk) begin
        if (Reset && w_done && r_is_write && w_is_arr) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

    assign Data_to_CPU = r_dout;
    assign HEX_out     = r_hex;
    assign R           = w_done;
    assign Busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder
module tb_mem_responder;

    localparam int WC       = 2;
    localparam int HOLD_REL = WC + 5;

    logic        Clk;
    logic        Reset;
    logic        CE_n, OE_n, WE_n;
    logic [15:0] ADDR, Data_from_CPU, Switches;
    logic [15:0] Data_to_CPU, HEX_out;
    logic        R, Busy;

    int total = 0;
    int bad   = 0;

    mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(WC), .IO_ADDR(16'hFFFF)) dut (
        .Clk(Clk), .Reset(Reset), .CE_n(CE_n), .OE_n(OE_n), .WE_n(WE_n),
        .ADDR(ADDR), .Data_from_CPU(Data_from_CPU), .Switches(Switches),
        .Data_to_CPU(Data_to_CPU), .R(R), .Busy(Busy), .HEX_out(HEX_out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        bit          wr;
        bit          rd;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] sw;
        logic [15:0] sw_late;
        int          rel;
        logic [15:0] ex_dout;
        logic [15:0] ex_hex;
    } vec_t;

    vec_t vecs[11];

    logic [15:0] m_mem [256];
    bit          m_valid [256];
    logic [15:0] m_hex;
    logic [15:0] m_dout;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: reads see Switches as they stand when the access completes
    task automatic model_apply(input bit wr, input logic [15:0] a, input logic [15:0] d,
                               input logic [15:0] sw);
        if (wr) begin
            if (a == 16'hFFFF) m_hex = d;
            else if (a < 16'd256) begin
                m_mem[a[7:0]]   = d;
                m_valid[a[7:0]] = 1'b1;
            end
        end else begin
            if (a == 16'hFFFF) m_dout = sw;
            else if (a < 16'd256) m_dout = m_mem[a[7:0]];
            else m_dout = 16'h0000;
        end
    endtask

    task automatic txn(input bit wr, input bit rd, input logic [15:0] a, input logic [15:0] d,
                       input logic [15:0] sw, input logic [15:0] swl, input int rel,
                       input logic [15:0] exd, input logic [15:0] exh);
        int rc, lat, bw;
        bw = 0;
        @(negedge Clk);
        while (Busy && bw < 20) begin
            @(negedge Clk);
            bw++;
        end
        chk("idle_before", {31'd0, Busy}, 32'd0);
        CE_n = 1'b0; OE_n = ~rd; WE_n = ~wr;
        ADDR = a; Data_from_CPU = d; Switches = sw;
        rc = 0; lat = -1;
        for (int n = 1; n <= WC + 8; n++) begin
            @(negedge Clk);
            if (n == 1) begin
                ADDR = ~a; Data_from_CPU = ~d; Switches = swl;
            end
            if (R) begin
                rc++;
                lat = n;
            end
            if (n == WC + 3) chk("busy_after_done", {31'd0, Busy}, {31'd0, rel > WC + 2});
            if (n == rel) begin
                CE_n = 1'b1; OE_n = 1'b1; WE_n = 1'b1;
            end
        end
        chk("r_pulses", rc, 1);
        chk("r_latency", lat, WC + 2);
        chk("data_to_cpu", {16'd0, Data_to_CPU}, {16'd0, exd});
        chk("hex_out", {16'd0, HEX_out}, {16'd0, exh});
        chk("busy_end", {31'd0, Busy}, 32'd0);
    endtask

    initial begin
        int rc;
        for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
        m_hex = 16'h0000; m_dout = 16'h0000;

        vecs[0]  = '{1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 16'h0000, HOLD_REL, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b0, 1'b1, 16'h0010, 16'h0000, 16'h0000, 16'h0000, HOLD_REL, 16'hBEEF, 16'h0000};
        vecs[2]  = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h1234, 16'h5678, 1,        16'h5678, 16'h0000};
        vecs[3]  = '{1'b1, 1'b0, 16'hFFFF, 16'h00A5, 16'h0000, 16'h0000, HOLD_REL, 16'h5678, 16'h00A5};
        vecs[4]  = '{1'b1, 1'b0, 16'h0000, 16'h1357, 16'h0000, 16'h0000, 1,        16'h5678, 16'h00A5};
        vecs[5]  = '{1'b0, 1'b1, 16'h0100, 16'h0000, 16'h0000, 16'h0000, HOLD_REL, 16'h0000, 16'h00A5};
        vecs[6]  = '{1'b1, 1'b0, 16'h0100, 16'h7777, 16'h0000, 16'h0000, 1,        16'h0000, 16'h00A5};
        vecs[7]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, HOLD_REL, 16'h1357, 16'h00A5};
        vecs[8]  = '{1'b1, 1'b1, 16'h0020, 16'h0042, 16'h0000, 16'h0000, 1,        16'h1357, 16'h00A5};
        vecs[9]  = '{1'b0, 1'b1, 16'h0020, 16'h0000, 16'h0000, 16'h0000, 1,        16'h0042, 16'h00A5};
        vecs[10] = '{1'b1, 1'b0, 16'h0005, 16'h1111, 16'h0000, 16'h0000, HOLD_REL, 16'h0042, 16'h00A5};

        // Reset held with a write pending on the strobes
        Reset = 1'b0; CE_n = 1'b0; OE_n = 1'b1; WE_n = 1'b0;
        ADDR = 16'h0030; Data_from_CPU = 16'h3030; Switches = 16'h0000;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("rst_r", {31'd0, R}, 32'd0);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_dout", {16'd0, Data_to_CPU}, 32'd0);
        chk("rst_hex", {16'd0, HEX_out}, 32'd0);
        Reset = 1'b1;
        @(negedge Clk);
        chk("accept_after_reset", {31'd0, Busy}, 32'd1);
        CE_n = 1'b1; WE_n = 1'b1;
        rc = 0;
        repeat (WC + 6) begin
            @(negedge Clk);
            if (R) rc++;
        end
        chk("first_req_r", rc, 1);
        model_apply(1'b1, 16'h0030, 16'h3030, 16'h0000);

        for (int i = 0; i < 11; i++) begin
            txn(vecs[i].wr, vecs[i].rd, vecs[i].a, vecs[i].d, vecs[i].sw, vecs[i].sw_late,
                vecs[i].rel, vecs[i].ex_dout, vecs[i].ex_hex);
            model_apply(vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].sw_late);
        end

        // Reset pulse in WAIT must abort the write to 0x0005
        @(negedge Clk);
        CE_n = 1'b0; OE_n = 1'b1; WE_n = 1'b0; ADDR = 16'h0005; Data_from_CPU = 16'hCAFE;
        @(negedge Clk);
        chk("abort_busy_wait", {31'd0, Busy}, 32'd1);
        Reset = 1'b0; CE_n = 1'b1; WE_n = 1'b1;
        #1;
        chk("abort_busy_rst", {31'd0, Busy}, 32'd0);
        rc = 0;
        @(negedge Clk);
        if (R) rc++;
        Reset = 1'b1;
        repeat (WC + 6) begin
            @(negedge Clk);
            if (R) rc++;
        end
        chk("abort_no_r", rc, 0);
        chk("abort_hex", {16'd0, HEX_out}, 32'd0);
        chk("abort_dout", {16'd0, Data_to_CPU}, 32'd0);
        m_hex = 16'h0000; m_dout = 16'h0000;
        txn(1'b0, 1'b1, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 1, 16'h1111, 16'h0000);
        model_apply(1'b0, 16'h0005, 16'h0000, 16'h0000);

        for (int k = 0; k < 40; k++) begin
            bit          wr, rd;
            logic [15:0] a, d, sw, swl;
            int          cls, rel;
            cls = $urandom_range(0, 3);
            d   = 16'($urandom);
            sw  = 16'($urandom);
            swl = 16'($urandom);
            rel = ($urandom_range(0, 1) == 0) ? 1 : HOLD_REL;
            wr  = 1'b0;
            case (cls)
                0: begin
                    wr = 1'b1;
                    a  = 16'($urandom_range(0, 255));
                end
                1: begin
                    a = 16'h0010;
                    for (int t = 0; t < 20; t++) begin
                        logic [15:0] c;
                        c = 16'($urandom_range(0, 255));
                        if (m_valid[c[7:0]]) begin
                            a = c;
                            break;
                        end
                    end
                end
                2: begin
                    wr = 1'($urandom_range(0, 1));
                    a  = 16'hFFFF;
                end
                default: begin
                    wr = 1'($urandom_range(0, 1));
                    a  = 16'h0100 + 16'($urandom_range(0, 16'hFDFE));
                end
            endcase
            rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            model_apply(wr, a, d, swl);
            txn(wr, rd, a, d, sw, swl, rel, m_dout, m_hex);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
